// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for two write-back requesters (ALU and load) feeding one
// register-file write port. It also keeps a per-register busy scoreboard.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [AW-1:0]      req0_idx,
    input  logic [DW-1:0]      req0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [AW-1:0]      req1_idx,
    input  logic [DW-1:0]      req1_data,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_idx,
    output logic               wr_en,
    output logic [AW-1:0]      wr_idx,
    output logic [DW-1:0]      wr_data,
    output logic [2**AW-1:0]   busy
);

    localparam int NREG = 2**AW;

    logic              last_reg, last_next;
    logic              wr_en_reg, wr_en_next;
    logic [AW-1:0]     wr_idx_reg, wr_idx_next;
    logic [DW-1:0]     wr_data_reg, wr_data_next;
    logic [NREG-1:0]   busy_reg, busy_next;

    logic              grant1;
    logic              xfer;
    logic [AW-1:0]     xfer_idx;
    logic [DW-1:0]     xfer_data;

    // last_reg holds the requester granted on the most recent transfer;
    // on a tie the other requester wins.
    always_comb begin
        grant1 = 1'b0;
        if (req1_valid && (!req0_valid || !last_reg))
            grant1 = 1'b1;
    end

    // Ready is forced low while reset is held, independent of the clock.
    assign req0_ready = rst_n & req0_valid & ~grant1;
    assign req1_ready = rst_n & req1_valid &  grant1;
    assign xfer       = req0_ready | req1_ready;
    assign xfer_idx   = grant1 ? req1_idx  : req0_idx;
    assign xfer_data  = grant1 ? req1_data : req0_data;

    always_comb begin
        last_next    = last_reg;
        wr_en_next   = 1'b0;
        wr_idx_next  = wr_idx_reg;
        wr_data_next = wr_data_reg;
        if (xfer) begin
            last_next = grant1;
            if (xfer_idx != '0) begin
                wr_en_next   = 1'b1;
                wr_idx_next  = xfer_idx;
                wr_data_next = xfer_data;
            end
        end
    end

    // Per-register scoreboard bit: a new reservation beats a same-edge clear.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit;
                logic clr_bit;
                assign set_bit       = rsv_valid && (rsv_idx == AW'(gi));
                assign clr_bit       = wr_en_next && (xfer_idx == AW'(gi));
                assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg    <= 1'b1;
            wr_en_reg   <= 1'b0;
            wr_idx_reg  <= '0;
            wr_data_reg <= '0;
            busy_reg    <= '0;
        end else begin
            last_reg    <= last_next;
            wr_en_reg   <= wr_en_next;
            wr_idx_reg  <= wr_idx_next;
            wr_data_reg <= wr_data_next;
            busy_reg    <= busy_next;
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_idx  = wr_idx_reg;
    assign wr_data = wr_data_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner sequence,
// then randomized traffic against a transaction-level reference model.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_idx;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_idx;
    logic [31:0] req1_data;
    logic        rsv_valid;
    logic [4:0]  rsv_idx;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_idx(req0_idx), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_idx(req1_idx), .req1_data(req1_data),
        .rsv_valid(rsv_valid), .rsv_idx(rsv_idx),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v0;
        logic [4:0]  i0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  i1;
        logic [31:0] d1;
        logic        rv;
        logic [4:0]  ri;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic [31:0] busy;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] i1, input logic [31:0] d1,
                         input logic rv, input logic [4:0] ri);
        req0_valid = v0; req0_idx = i0; req0_data = d0;
        req1_valid = v1; req1_idx = i1; req1_data = d1;
        rsv_valid  = rv; rsv_idx  = ri;
    endtask

    // One full cycle: drive at negedge, check ready before the edge, outputs after.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v.v0, v.i0, v.d0, v.v1, v.i1, v.d1, v.rv, v.ri);
        #1;
        chk({tag, " req0_ready"}, 64'(req0_ready), 64'(v.r0));
        chk({tag, " req1_ready"}, 64'(req1_ready), 64'(v.r1));
        @(posedge clk);
        #1;
        chk({tag, " wr_en"},   64'(wr_en),   64'(v.en));
        chk({tag, " wr_idx"},  64'(wr_idx),  64'(v.widx));
        chk({tag, " wr_data"}, 64'(wr_data), 64'(v.wdata));
        chk({tag, " busy"},    64'(busy),    64'(v.busy));
        $display("%s: rdy=%0b%0b wr_en=%0b wr_idx=%0d wr_data=%h busy=%h",
                 tag, req0_ready, req1_ready, wr_en, wr_idx, wr_data, busy);
    endtask

    // Reference model state (tie winner, expected write port, scoreboard).
    logic        m_prefer1;
    logic        m_en;
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    logic [31:0] m_busy;

    logic        p0v, p1v;
    logic [4:0]  p0i, p1i;
    logic [31:0] p0d, p1d;

    initial begin
        vec_t v;
        tbl[0]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 32'h0};
        tbl[1]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h22, 32'h0};
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[1];
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2, 32'h22, 32'h0};
        tbl[5]  = '{1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hA5A5A5A5, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd5, 32'hA5A5A5A5, 32'h80};
        tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 32'h0};
        tbl[9]  = '{1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 32'h200};
        tbl[10] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h200};
        tbl[11] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 32'h200};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd9, 32'h5, 32'h80};

        // Reset state, with both requesters already asserting valid.
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6);
        #1;
        chk("reset req0_ready", 64'(req0_ready), 64'd0);
        chk("reset req1_ready", 64'(req1_ready), 64'd0);
        chk("reset wr_en",      64'(wr_en),      64'd0);
        chk("reset wr_idx",     64'(wr_idx),     64'd0);
        chk("reset wr_data",    64'(wr_data),    64'd0);
        chk("reset busy",       64'(busy),       64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset held busy", 64'(busy), 64'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Build busy=0x84, then a req0 transfer lands just before reset.
        v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 32'h5, 32'h84};
        run_vec(v, "pre_rst_rsv");
        v = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 32'h84};
        run_vec(v, "pre_rst_xfer");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst wr_en",      64'(wr_en),      64'd0);
        chk("midrst wr_idx",     64'(wr_idx),     64'd0);
        chk("midrst wr_data",    64'(wr_data),    64'd0);
        chk("midrst busy",       64'(busy),       64'd0);
        chk("midrst req0_ready", 64'(req0_ready), 64'd0);
        chk("midrst req1_ready", 64'(req1_ready), 64'd0);
        $display("midrst: wr_en=%0b busy=%h", wr_en, busy);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst wr_en",      64'(wr_en),      64'd0);
        chk("postrst req0_ready", 64'(req0_ready), 64'd1);
        chk("postrst req1_ready", 64'(req1_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("postrst wr_en1",  64'(wr_en),   64'd1);
        chk("postrst wr_idx",  64'(wr_idx),  64'd3);
        chk("postrst wr_data", 64'(wr_data), 64'h33);
        $display("postrst: wr_en=%0b wr_idx=%0d wr_data=%h", wr_en, wr_idx, wr_data);

        // Randomized traffic. Requesters hold their request until accepted.
        m_prefer1 = 1'b1;
        m_en = 1'b1; m_idx = 5'd3; m_data = 32'h33; m_busy = 32'h0;
        p0v = 1'b0; p1v = 1'b0;
        p0i = '0; p1i = '0; p0d = '0; p1d = '0;
        for (int c = 0; c < 400; c++) begin
            logic        g1, e0, e1, rv;
            logic [4:0]  ri, ti;
            logic [31:0] td, set_m, clr_m;
            @(negedge clk);
            if (!p0v && ($urandom % 3 != 0)) begin
                p0v = 1'b1; p0i = 5'($urandom); p0d = $urandom;
            end
            if (!p1v && ($urandom % 3 != 0)) begin
                p1v = 1'b1; p1i = 5'($urandom); p1d = $urandom;
            end
            rv = ($urandom % 4 == 0);
            ri = 5'($urandom);
            drive(p0v, p0i, p0d, p1v, p1i, p1d, rv, ri);
            g1 = (p0v && p1v) ? m_prefer1 : p1v;
            e0 = p0v && !g1;
            e1 = p1v && g1;
            #1;
            chk($sformatf("rnd%0d req0_ready", c), 64'(req0_ready), 64'(e0));
            chk($sformatf("rnd%0d req1_ready", c), 64'(req1_ready), 64'(e1));
            @(posedge clk);
            #1;
            ti = g1 ? p1i : p0i;
            td = g1 ? p1d : p0d;
            set_m = (rv && ri != 0) ? (32'h1 << ri) : 32'h0;
            clr_m = 32'h0;
            m_en = 1'b0;
            if (e0 || e1) begin
                m_prefer1 = !g1;
                if (ti != 0) begin
                    m_en = 1'b1; m_idx = ti; m_data = td;
                    clr_m = 32'h1 << ti;
                end
                if (g1) p1v = 1'b0; else p0v = 1'b0;
            end
            m_busy = ((m_busy & ~clr_m) | set_m) & 32'hFFFF_FFFE;
            chk($sformatf("rnd%0d wr_en", c),   64'(wr_en),   64'(m_en));
            chk($sformatf("rnd%0d wr_idx", c),  64'(wr_idx),  64'(m_idx));
            chk($sformatf("rnd%0d wr_data", c), 64'(wr_data), 64'(m_data));
            chk($sformatf("rnd%0d busy", c),    64'(busy),    64'(m_busy));
            $display("rnd%0d: rdy=%0b%0b wr_en=%0b wr_idx=%0d wr_data=%h busy=%h",
                     c, req0_ready, req1_ready, wr_en, wr_idx, wr_data, busy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
